// File: rtl/surprise_slot_manager.sv
// rtl/surprise_slot_manager.sv - enable, score-queue and respawn state for the on-screen surprise slots
module surprise_slot_manager #(
    parameter int N_SLOTS        = 8,
    parameter int RESPAWN_FRAMES = 120,
    parameter int TIMER_W        = 8
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 pause,
    input  logic                 hit_valid,
    input  logic [N_SLOTS-1:0]   hit_bus,
    input  logic                 level_load,
    input  logic [N_SLOTS-1:0]   level_mask,
    output logic [N_SLOTS-1:0]   enable_all,
    output logic                 score_valid,
    output logic [2:0]           score_slot,
    output logic                 all_collected
);

    localparam logic [TIMER_W-1:0] RespawnLoad = TIMER_W'(RESPAWN_FRAMES);

    logic [N_SLOTS-1:0] activeMask;
    logic [N_SLOTS-1:0] pending;
    logic [TIMER_W-1:0] timer [N_SLOTS];

    logic [N_SLOTS-1:0] hitMask;
    logic [N_SLOTS-1:0] drainClear;
    logic [2:0]         drainIdx;
    logic               drainAny;
    logic               frameTick;

    // Qualify hits against currently enabled slots and pick the lowest pending slot to score.
    always_comb begin
        hitMask    = {N_SLOTS{hit_valid}} & hit_bus & enable_all;
        drainAny   = |pending;
        drainIdx   = 3'd0;
        drainClear = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                drainIdx = 3'(i);
            end
        end
        if (drainAny) begin
            drainClear[drainIdx] = 1'b1;
        end
        frameTick = startOfFrame & ~pause;
    end

    // Slot state: reset, then level load, otherwise hits, score drain and frame-based respawn.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            enable_all  <= '1;
            activeMask  <= '1;
            pending     <= '0;
            score_valid <= 1'b0;
            score_slot  <= 3'd0;
            for (int i = 0; i < N_SLOTS; i++) begin
                timer[i] <= '0;
            end
        end else if (level_load) begin
            enable_all  <= level_mask;
            activeMask  <= level_mask;
            pending     <= '0;
            score_valid <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                timer[i] <= '0;
            end
        end else begin
            // Drain works on the pending set as it stood before this edge's hits arrive.
            score_valid <= drainAny;
            if (drainAny) begin
                score_slot <= drainIdx;
            end
            pending <= (pending & ~drainClear) | hitMask;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (hitMask[i]) begin
                    // A hit always takes the full reload; a coincident frame is not counted.
                    enable_all[i] <= 1'b0;
                    timer[i]      <= RespawnLoad;
                end else if (frameTick && !enable_all[i] && activeMask[i] && timer[i] != '0) begin
                    timer[i] <= timer[i] - 1'b1;
                    if (timer[i] == TIMER_W'(1)) begin
                        enable_all[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Level is cleared once every active slot is taken and every score has been issued.
    always_comb begin
        all_collected = (activeMask != '0) && ((enable_all & activeMask) == '0) && (pending == '0);
    end

endmodule

// File: tb/tb_surprise_slot_manager.sv
// tb/tb_surprise_slot_manager.sv - directed self-checking bench for surprise_slot_manager
module tb_surprise_slot_manager;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       pause;
    logic       hit_valid;
    logic [7:0] hit_bus;
    logic       level_load;
    logic [7:0] level_mask;
    logic [7:0] enable_all;
    logic       score_valid;
    logic [2:0] score_slot;
    logic       all_collected;

    int errors = 0;
    int checks = 0;

    surprise_slot_manager #(
        .N_SLOTS(8),
        .RESPAWN_FRAMES(3),
        .TIMER_W(8)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .pause(pause),
        .hit_valid(hit_valid),
        .hit_bus(hit_bus),
        .level_load(level_load),
        .level_mask(level_mask),
        .enable_all(enable_all),
        .score_valid(score_valid),
        .score_slot(score_slot),
        .all_collected(all_collected)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        startOfFrame = 1'b0;
        pause        = 1'b0;
        hit_valid    = 1'b0;
        hit_bus      = 8'h00;
        level_load   = 1'b0;
        level_mask   = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (enable_all !== 8'hFF) begin errors++; $display("FAIL reset_enable: got %h want ff", enable_all); end
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL reset_score_valid: got %b want 0", score_valid); end
        checks++; if (score_slot !== 3'd0) begin errors++; $display("FAIL reset_score_slot: got %0d want 0", score_slot); end
        checks++; if (all_collected !== 1'b0) begin errors++; $display("FAIL reset_all_collected: got %b want 0", all_collected); end
    endtask

    task automatic test_single_hit();
        do_reset();
        hit_valid = 1'b1; hit_bus = 8'h04;
        tick();
        idle_inputs();
        checks++; if (enable_all !== 8'hFB) begin errors++; $display("FAIL single_enable: got %h want fb", enable_all); end
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL single_no_early_score: got %b want 0", score_valid); end
        tick();
        checks++; if (score_valid !== 1'b1 || score_slot !== 3'd2) begin errors++; $display("FAIL single_score: got v=%b s=%0d want v=1 s=2", score_valid, score_slot); end
        tick();
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", score_valid); end
    endtask

    task automatic test_multi_hit();
        logic [2:0] expSlot [3];
        expSlot[0] = 3'd0; expSlot[1] = 3'd5; expSlot[2] = 3'd7;
        do_reset();
        hit_valid = 1'b1; hit_bus = 8'hA1;
        tick();
        idle_inputs();
        checks++; if (enable_all !== 8'h5E) begin errors++; $display("FAIL multi_enable: got %h want 5e", enable_all); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (score_valid !== 1'b1 || score_slot !== expSlot[k]) begin errors++; $display("FAIL multi_score%0d: got v=%b s=%0d want v=1 s=%0d", k, score_valid, score_slot, expSlot[k]); end
        end
        tick();
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL multi_drain_end: got %b want 0", score_valid); end
    endtask

    task automatic test_respawn_pause();
        do_reset();
        hit_valid = 1'b1; hit_bus = 8'h02;
        tick();
        idle_inputs();
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        startOfFrame = 1'b1; pause = 1'b1; tick(); startOfFrame = 1'b0; pause = 1'b0; tick();
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        checks++; if (enable_all[1] !== 1'b0) begin errors++; $display("FAIL respawn_early: got %b want 0", enable_all[1]); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        checks++; if (enable_all !== 8'hFF) begin errors++; $display("FAIL respawn_return: got %h want ff", enable_all); end
    endtask

    task automatic test_hit_with_frame();
        do_reset();
        hit_valid = 1'b1; hit_bus = 8'h08; startOfFrame = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        end
        checks++; if (enable_all[3] !== 1'b0) begin errors++; $display("FAIL hitframe_early: got %b want 0", enable_all[3]); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        checks++; if (enable_all[3] !== 1'b1) begin errors++; $display("FAIL hitframe_return: got %b want 1", enable_all[3]); end
    endtask

    task automatic test_level_load();
        do_reset();
        level_load = 1'b1; level_mask = 8'h03; hit_valid = 1'b1; hit_bus = 8'h01;
        tick();
        idle_inputs();
        checks++; if (enable_all !== 8'h03) begin errors++; $display("FAIL level_enable: got %h want 03", enable_all); end
        checks++; if (score_valid !== 1'b0 || all_collected !== 1'b0) begin errors++; $display("FAIL level_quiet: got v=%b ac=%b want 0 0", score_valid, all_collected); end
        tick();
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL level_dropped_hit: got %b want 0", score_valid); end
        hit_valid = 1'b1; hit_bus = 8'h03;
        tick();
        idle_inputs();
        checks++; if (enable_all !== 8'h00 || all_collected !== 1'b0) begin errors++; $display("FAIL level_hit: got en=%h ac=%b want 00 0", enable_all, all_collected); end
        tick();
        checks++; if (score_valid !== 1'b1 || score_slot !== 3'd0 || all_collected !== 1'b0) begin errors++; $display("FAIL level_score0: got v=%b s=%0d ac=%b want 1 0 0", score_valid, score_slot, all_collected); end
        tick();
        checks++; if (score_valid !== 1'b1 || score_slot !== 3'd1 || all_collected !== 1'b1) begin errors++; $display("FAIL level_score1: got v=%b s=%0d ac=%b want 1 1 1", score_valid, score_slot, all_collected); end
        tick();
        checks++; if (score_valid !== 1'b0 || all_collected !== 1'b1) begin errors++; $display("FAIL level_done: got v=%b ac=%b want 0 1", score_valid, all_collected); end
    endtask

    task automatic test_rehit_disabled();
        do_reset();
        hit_valid = 1'b1; hit_bus = 8'h10;
        tick();
        idle_inputs();
        tick();
        checks++; if (score_valid !== 1'b1 || score_slot !== 3'd4) begin errors++; $display("FAIL rehit_first_score: got v=%b s=%0d want 1 4", score_valid, score_slot); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        hit_valid = 1'b1; hit_bus = 8'h10;
        tick();
        idle_inputs();
        tick();
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL rehit_no_score: got %b want 0", score_valid); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
        checks++; if (enable_all[4] !== 1'b0) begin errors++; $display("FAIL rehit_early: got %b want 0", enable_all[4]); end
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
        checks++; if (enable_all[4] !== 1'b1) begin errors++; $display("FAIL rehit_no_reload: got %b want 1", enable_all[4]); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        hit_valid = 1'b1; hit_bus = 8'hFF;
        tick();
        idle_inputs();
        tick();
        checks++; if (score_valid !== 1'b1 || score_slot !== 3'd0) begin errors++; $display("FAIL middrain_first: got v=%b s=%0d want 1 0", score_valid, score_slot); end
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        checks++; if (score_valid !== 1'b0 || enable_all !== 8'hFF) begin errors++; $display("FAIL middrain_reset: got v=%b en=%h want 0 ff", score_valid, enable_all); end
        tick();
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL middrain_discard: got %b want 0", score_valid); end
    endtask

    initial begin
        idle_inputs();
        resetN = 1'b0;
        test_reset();
        test_single_hit();
        test_multi_hit();
        test_respawn_pause();
        test_hit_with_frame();
        test_level_load();
        test_rehit_disabled();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/surprise_slot_manager.md
# surprise_slot_manager

Owns the enable state of the 8 surprise slots on screen. It clears a slot when Bumpy collects it and queues one score event per collected slot. After a configurable number of frames it re-enables the slot, and it reloads the slot set on each level load. It sits between the collision/hit detection logic (upstream) and the surprise drawing/score logic (downstream), which consume `enable_all` and the score pulses.

## Interface
Parameters:
- `N_SLOTS`, 8 — number of surprise slots; the logic is written for 8.
- `RESPAWN_FRAMES`, 120 — frames from collection until the slot re-enables; 0 means a collected slot never respawns.
- `TIMER_W`, 8 — width of each per-slot respawn timer; `RESPAWN_FRAMES` must be < 2^`TIMER_W`.

Ports:
- `clk`  in  1 — single system clock; every register updates on its rising edge.
- `resetN`  in  1 — synchronous, active-low reset, sampled on the rising edge of `clk`.
- `startOfFrame`  in  1 — one-cycle pulse, once per video frame.
- `pause`  in  1 — level-sensitive; freezes the respawn timers only.
- `hit_valid`  in  1 — qualifies `hit_bus` in the same cycle.
- `hit_bus`  in  8 — slots hit this cycle; more than one bit may be set.
- `level_load`  in  1 — one-cycle pulse that loads a new slot set.
- `level_mask`  in  8 — slots active in the new level; sampled when `level_load`=1.
- `enable_all`  out  8 — registered; bit i=1 means slot i is drawn and collectable.
- `score_valid`  out  1 — registered; one-cycle pulse per collected slot.
- `score_slot`  out  3 — registered; index of the collected slot, meaningful when `score_valid`=1.
- `all_collected`  out  1 — decode of internal registers: `active_mask`≠0, and (`enable_all` & `active_mask`)=0, and `pending`=0.

## Operation
- Internal state:
  - `active_mask`[7:0]: slots belonging to the current level.
  - `pending`[7:0]: collected slots whose score event has not yet been issued.
  - `timer`[i], i=0..7: respawn countdown per slot.
- Reset (`resetN`=0 at an edge) sets:
  - `enable_all`=8'hFF and `active_mask`=8'hFF;
  - `pending`=0 and all timers=0;
  - `score_valid`=0 and `score_slot`=0.
  - `all_collected` therefore reads 0.
  - Reset asserted mid-drain discards any queued score events.
- Level load (`level_load`=1) has the highest non-reset priority. On that edge:
  - `enable_all` and `active_mask` take `level_mask`;
  - `pending` and all timers clear;
  - `score_valid` goes to 0;
  - any `hit_valid` in the same cycle is dropped.
- Hit: for each bit i with `hit_valid` & `hit_bus`[i] & `enable_all`[i]:
  - clear `enable_all`[i];
  - set `pending`[i];
  - load `timer`[i] with `RESPAWN_FRAMES`.
  - A hit on a disabled slot is ignored: no score, and its timer is not reloaded.
- Score drain: on each edge where `pending`≠0 (before this edge's hits are merged):
  - select the lowest set index k;
  - drive `score_valid`=1 and `score_slot`=k;
  - clear `pending`[k].
  - Otherwise `score_valid`=0. Throughput is exactly one event per cycle. New hits OR into `pending` while a drain is in progress.
- Respawn: on an edge with `startOfFrame`=1 and `pause`=0, for each slot i with `enable_all`[i]=0, `active_mask`[i]=1 and `timer`[i]>0:
  - decrement `timer`[i];
  - on the 1→0 transition, set `enable_all`[i] in the same edge.
  - With `RESPAWN_FRAMES`=0 the timers stay 0 and slots never return.
- Simultaneous events:
  - A hit and a respawn on the same slot cannot coincide: a hit requires the slot enabled, a respawn requires it disabled.
  - If a hit and `startOfFrame` arrive together, the hit loads the full `RESPAWN_FRAMES` and that frame is not counted.
  - `pause`=1 still processes hits and drains scores.

## Timing
- Hit sampled at edge t: `enable_all` bit low from t; `pending` bit set from t.
- First score pulse from edge t+1. For m simultaneous hits, pulses come out on edges t+1 … t+m in ascending slot order.
- Respawn completes on the m-th unpaused `startOfFrame` edge after the hit edge, where m=`RESPAWN_FRAMES`.
- `level_load` takes effect at the next edge; `all_collected` settles in the same cycle as the state it decodes.
- No combinational path from any input to any output.

## Test plan
- Reset, then `hit_valid`=1, `hit_bus`=8'h04 → `enable_all`=8'hFB after 1 edge; `score_valid`=1, `score_slot`=2 on the next edge for exactly one cycle.
- Hit with `hit_bus`=8'hA1 → `score_slot` sequence 0,5,7 on 3 consecutive cycles; `enable_all`=8'h5E.
- `RESPAWN_FRAMES`=3: hit slot 1, then 3 `startOfFrame` pulses with one `pause`-masked pulse in between → bit 1 returns only on the 4th pulse edge.
- `level_load` with `level_mask`=8'h03 in the same cycle as a hit on 8'h01 → `enable_all`=8'h03, no score. Then hit 8'h03 → two scores, and `all_collected`=1 once the drain ends.
- Second hit on an already-collected slot 4 while its timer runs → no score, timer not reloaded. `resetN`=0 mid-drain → `score_valid`=0, `enable_all`=8'hFF at the next edge.
